// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: forward-select codes,
// FSM state encodings and the default divider latency.
package hazard_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    localparam int DIV_CYCLES_DEF = 32;

    typedef enum logic [1:0] {
        D_IDLE = 2'b00,
        D_BUSY = 2'b01,
        D_DONE = 2'b10
    } divState_e;

    typedef enum logic [1:0] {
        M_IDLE = 2'b00,
        M_REQ  = 2'b01,
        M_WAIT = 2'b10
    } memState_e;

    // A producer only matters when it writes a real register that a consumer reads.
    function automatic logic regHit(input logic wr, input logic [4:0] dst, input logic [4:0] src);
        return wr && (dst != 5'd0) && (dst == src);
    endfunction

endpackage

// File: rtl/haz_mem_fsm.sv
// Data-memory request/address-ok/data-ok handshake sequencer; a started
// transaction always runs to its data_data_ok beat.
module haz_mem_fsm
    import hazard_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic memreadM,
    input  logic memwriteM,
    input  logic excM,
    input  logic data_addr_ok,
    input  logic data_data_ok,
    output logic data_req,
    output logic memStall,
    output logic memIdle,
    output logic memDone
);

    memState_e state;
    memState_e stateNext;
    logic      memOp;

    assign memOp   = (memreadM | memwriteM) & ~excM;
    assign memIdle = (state == M_IDLE);
    assign memDone = (state == M_WAIT) & data_data_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= M_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        data_req  = 1'b0;
        memStall  = 1'b0;
        case (state)
            M_IDLE: begin
                if (memOp) begin
                    data_req  = 1'b1;
                    memStall  = 1'b1;
                    stateNext = data_addr_ok ? M_WAIT : M_REQ;
                end
            end
            M_REQ: begin
                data_req = 1'b1;
                memStall = 1'b1;
                if (data_addr_ok) begin
                    stateNext = M_WAIT;
                end
            end
            M_WAIT: begin
                memStall = ~data_data_ok;
                if (data_data_ok) begin
                    stateNext = M_IDLE;
                end
            end
            default: stateNext = M_IDLE;
        endcase
        // Reset drops the request line immediately, not at the next edge.
        if (rst) begin
            data_req = 1'b0;
            memStall = 1'b0;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forwarding control for the 5-stage MIPS pipeline.
// Define HAZ_BRANCH_FWD_EN to forward M-stage results to the decode branch compare.
module pipe_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int DIV_CYCLES = DIV_CYCLES_DEF,
    parameter int CNT_W      = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rsD,
    input  logic [4:0] rtD,
    input  logic       branchD,
    input  logic [4:0] rsE,
    input  logic [4:0] rtE,
    input  logic [4:0] writeregE,
    input  logic       regwriteE,
    input  logic       memtoregE,
    input  logic       divE,
    input  logic [4:0] writeregM,
    input  logic       regwriteM,
    input  logic       memtoregM,
    input  logic       memreadM,
    input  logic       memwriteM,
    input  logic       excM,
    input  logic [4:0] writeregW,
    input  logic       regwriteW,
    input  logic       data_addr_ok,
    input  logic       data_data_ok,
    output logic       data_req,
    output logic       div_start,
    output logic [1:0] forwardAE,
    output logic [1:0] forwardBE,
    output logic       forwardAD,
    output logic       forwardBD,
    output logic       stallF,
    output logic       stallD,
    output logic       stallE,
    output logic       stallM,
    output logic       stallW,
    output logic       flushD,
    output logic       flushE,
    output logic       flushM,
    output logic       flushW
);

    logic memStall;
    logic memIdle;
    logic memDone;

    haz_mem_fsm uMemFsm (
        .clk          (clk),
        .rst          (rst),
        .memreadM     (memreadM),
        .memwriteM    (memwriteM),
        .excM         (excM),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_req     (data_req),
        .memStall     (memStall),
        .memIdle      (memIdle),
        .memDone      (memDone)
    );

    // Execute-stage operand forwarding; M is younger than W so it wins.
    always_comb begin
        forwardAE = FWD_RF;
        forwardBE = FWD_RF;
        if (regHit(regwriteM, writeregM, rsE)) begin
            forwardAE = FWD_M;
        end else if (regHit(regwriteW, writeregW, rsE)) begin
            forwardAE = FWD_W;
        end
        if (regHit(regwriteM, writeregM, rtE)) begin
            forwardBE = FWD_M;
        end else if (regHit(regwriteW, writeregW, rtE)) begin
            forwardBE = FWD_W;
        end
        if (rst) begin
            forwardAE = FWD_RF;
            forwardBE = FWD_RF;
        end
    end

    logic lwStall;
    logic branchStall;
    logic prodEHit;

    assign lwStall  = regHit(memtoregE, rtE, rsD) | regHit(memtoregE, rtE, rtD);
    assign prodEHit = regHit(regwriteE, writeregE, rsD) | regHit(regwriteE, writeregE, rtD);

`ifdef HAZ_BRANCH_FWD_EN
    assign forwardAD   = ~rst & regHit(regwriteM, writeregM, rsD);
    assign forwardBD   = ~rst & regHit(regwriteM, writeregM, rtD);
    // ALU results in M reach the comparator; only loads in M still have to wait.
    assign branchStall = branchD & (prodEHit |
                                    regHit(memtoregM, writeregM, rsD) |
                                    regHit(memtoregM, writeregM, rtD));
`else
    logic unusedMemtoregM;
    assign unusedMemtoregM = memtoregM;
    assign forwardAD   = 1'b0;
    assign forwardBD   = 1'b0;
    // Without a decode bypass the branch waits until its producer reaches W.
    assign branchStall = branchD & (prodEHit |
                                    regHit(regwriteM, writeregM, rsD) |
                                    regHit(regwriteM, writeregM, rtD));
`endif

    divState_e        divState;
    divState_e        divNext;
    logic [CNT_W-1:0] divCnt;
    logic [CNT_W-1:0] divCntNext;
    logic             divLaunch;
    logic             divStall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            divState <= D_IDLE;
            divCnt   <= '0;
        end else begin
            divState <= divNext;
            divCnt   <= divCntNext;
        end
    end

    // The launch cycle counts as the first of the DIV_CYCLES stall cycles.
    always_comb begin
        divNext    = divState;
        divCntNext = divCnt;
        divLaunch  = 1'b0;
        divStall   = 1'b0;
        case (divState)
            D_IDLE: begin
                if (divE && !excM) begin
                    divLaunch  = 1'b1;
                    divStall   = 1'b1;
                    divCntNext = CNT_W'(DIV_CYCLES - 1);
                    divNext    = D_BUSY;
                end
            end
            D_BUSY: begin
                divStall   = 1'b1;
                divCntNext = divCnt - CNT_W'(1);
                if (divCntNext == '0) begin
                    divNext = D_DONE;
                end
            end
            D_DONE:  divNext = D_IDLE;
            default: divNext = D_IDLE;
        endcase
        if (excM) begin
            divNext    = D_IDLE;
            divCntNext = '0;
        end
    end

    assign div_start = divLaunch & ~rst;

    // An exception seen while a transaction is in flight is held until it completes.
    logic excPend;
    logic excFlush;

    assign excFlush = (excM | excPend) & (memIdle | memDone);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            excPend <= 1'b0;
        end else if (excFlush) begin
            excPend <= 1'b0;
        end else if (excM) begin
            excPend <= 1'b1;
        end
    end

    assign stallW = 1'b0;

    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        stallM = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        flushM = 1'b0;
        flushW = 1'b0;
        if (!rst) begin
            if (excFlush) begin
                flushD = 1'b1;
                flushE = 1'b1;
                flushM = 1'b1;
                flushW = 1'b1;
            end else if (memStall) begin
                stallF = 1'b1;
                stallD = 1'b1;
                stallE = 1'b1;
                stallM = 1'b1;
                flushW = 1'b1;
            end else if (divStall) begin
                stallF = 1'b1;
                stallD = 1'b1;
                stallE = 1'b1;
                flushM = 1'b1;
            end else if (lwStall || branchStall) begin
                stallF = 1'b1;
                stallD = 1'b1;
                flushE = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized
// forwarding/interlock and memory-latency cases against a behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int DIVC = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic       branchD, regwriteE, memtoregE, divE;
    logic       regwriteM, memtoregM, memreadM, memwriteM, excM, regwriteW;
    logic       data_addr_ok, data_data_ok;
    logic       data_req, div_start, forwardAD, forwardBD;
    logic [1:0] forwardAE, forwardBE;
    logic       stallF, stallD, stallE, stallM, stallW;
    logic       flushD, flushE, flushM, flushW;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.DIV_CYCLES(DIVC), .CNT_W(6)) dut (
        .clk(clk), .rst(rst),
        .rsD(rsD), .rtD(rtD), .branchD(branchD),
        .rsE(rsE), .rtE(rtE), .writeregE(writeregE),
        .regwriteE(regwriteE), .memtoregE(memtoregE), .divE(divE),
        .writeregM(writeregM), .regwriteM(regwriteM), .memtoregM(memtoregM),
        .memreadM(memreadM), .memwriteM(memwriteM), .excM(excM),
        .writeregW(writeregW), .regwriteW(regwriteW),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_req(data_req), .div_start(div_start),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .forwardAD(forwardAD), .forwardBD(forwardBD),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM), .stallW(stallW),
        .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW)
    );

    logic [16:0] obs;
    assign obs = {data_req, div_start, forwardAE, forwardBE, forwardAD, forwardBD,
                  stallF, stallD, stallE, stallM, stallW, flushD, flushE, flushM, flushW};

    localparam logic [4:0] ST_MEM = 5'b11110, ST_DIV = 5'b11100, ST_DEC = 5'b11000;
    localparam logic [3:0] FL_MEM = 4'b0001, FL_DIV = 4'b0010, FL_DEC = 4'b0100, FL_EXC = 4'b1111;

    function automatic logic [16:0] mk(input logic req, input logic st, input logic [1:0] fa,
                                       input logic [1:0] fb, input logic fad, input logic fbd,
                                       input logic [4:0] stalls, input logic [3:0] flushes);
        return {req, st, fa, fb, fad, fbd, stalls, flushes};
    endfunction

    function automatic logic hit(input logic we, input logic [4:0] dst, input logic [4:0] src);
        return we && (dst != 5'd0) && (dst == src);
    endfunction

    function automatic logic [1:0] fwdSel(input logic [4:0] src);
        if (hit(regwriteM, writeregM, src)) return 2'b10;
        if (hit(regwriteW, writeregW, src)) return 2'b01;
        return 2'b00;
    endfunction

    task automatic clearInputs();
        rsD = 0; rtD = 0; rsE = 0; rtE = 0; writeregE = 0; writeregM = 0; writeregW = 0;
        branchD = 0; regwriteE = 0; memtoregE = 0; divE = 0;
        regwriteM = 0; memtoregM = 0; memreadM = 0; memwriteM = 0; excM = 0; regwriteW = 0;
        data_addr_ok = 0; data_data_ok = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clearInputs();
        memwriteM = 1; divE = 1; regwriteM = 1; writeregM = 3; rsE = 3; branchD = 1; rsD = 3;
        @(negedge clk); @(negedge clk); #1;
        total++;
        if (obs !== 17'd0) begin
            bad++; $display("FAIL reset_hold got=%b exp=%b", obs, 17'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        clearInputs();
        #1;
        total++;
        if (obs !== 17'd0) begin
            bad++; $display("FAIL reset_release got=%b exp=%b", obs, 17'd0);
        end
    endtask

    task automatic test_load_use();
        logic [16:0] e;
        // LW r2 in E, ADD r3,r2,r4 in D
        @(negedge clk); clearInputs();
        memtoregE = 1; regwriteE = 1; writeregE = 2; rtE = 2; rsE = 1; rsD = 2; rtD = 4;
        #1; e = mk(0, 0, 2'b00, 2'b00, 0, 0, ST_DEC, FL_DEC);
        total++;
        if (obs !== e) begin bad++; $display("FAIL load_use_stall got=%b exp=%b", obs, e); end
        // ADD now in E, LW in W
        @(negedge clk); clearInputs();
        rsE = 2; rtE = 4; regwriteW = 1; writeregW = 2;
        #1; e = mk(0, 0, 2'b01, 2'b00, 0, 0, 5'd0, 4'd0);
        total++;
        if (obs !== e) begin bad++; $display("FAIL load_use_fwd got=%b exp=%b", obs, e); end
        // M beats W; register 0 never forwards or interlocks
        @(negedge clk); clearInputs();
        regwriteM = 1; writeregM = 7; regwriteW = 1; writeregW = 7; rsE = 7; rtE = 0;
        memtoregE = 1; rsD = 0;
        #1; e = mk(0, 0, 2'b10, 2'b00, 0, 0, 5'd0, 4'd0);
        total++;
        if (obs !== e) begin bad++; $display("FAIL fwd_prio_r0 got=%b exp=%b", obs, e); end
    endtask

    task automatic test_forward_random();
        logic [16:0] e;
        logic lw, br, fad, fbd;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk); clearInputs();
            rsD = 5'($urandom_range(0, 7)); rtD = 5'($urandom_range(0, 7));
            rsE = 5'($urandom_range(0, 7)); rtE = 5'($urandom_range(0, 7));
            writeregE = 5'($urandom_range(0, 7)); writeregM = 5'($urandom_range(0, 7));
            writeregW = 5'($urandom_range(0, 7));
            regwriteE = 1'($urandom_range(0, 1)); memtoregE = 1'($urandom_range(0, 1));
            regwriteM = 1'($urandom_range(0, 1)); memtoregM = 1'($urandom_range(0, 1));
            regwriteW = 1'($urandom_range(0, 1)); branchD = 1'($urandom_range(0, 1));
            #1;
            lw = hit(memtoregE, rtE, rsD) || hit(memtoregE, rtE, rtD);
`ifdef HAZ_BRANCH_FWD_EN
            br  = branchD && (hit(regwriteE, writeregE, rsD) || hit(regwriteE, writeregE, rtD) ||
                              hit(memtoregM, writeregM, rsD) || hit(memtoregM, writeregM, rtD));
            fad = hit(regwriteM, writeregM, rsD);
            fbd = hit(regwriteM, writeregM, rtD);
`else
            br  = branchD && (hit(regwriteE, writeregE, rsD) || hit(regwriteE, writeregE, rtD) ||
                              hit(regwriteM, writeregM, rsD) || hit(regwriteM, writeregM, rtD));
            fad = 1'b0;
            fbd = 1'b0;
`endif
            e = mk(0, 0, fwdSel(rsE), fwdSel(rtE), fad, fbd,
                   (lw || br) ? ST_DEC : 5'd0, (lw || br) ? FL_DEC : 4'd0);
            total++;
            if (obs !== e) begin bad++; $display("FAIL fwd_random[%0d] got=%b exp=%b", i, obs, e); end
        end
    endtask

    task automatic test_branch();
        logic [16:0] e;
        int stalls = 0;
        int expStalls;
`ifdef HAZ_BRANCH_FWD_EN
        expStalls = 1;
`else
        expStalls = 2;
`endif
        // BEQ r5,r6 in D, ADD r5 in E
        @(negedge clk); clearInputs();
        branchD = 1; rsD = 5; rtD = 6; regwriteE = 1; writeregE = 5;
        #1; e = mk(0, 0, 2'b00, 2'b00, 0, 0, ST_DEC, FL_DEC);
        if (stallD === 1'b1) stalls++;
        total++;
        if (obs !== e) begin bad++; $display("FAIL branch_e got=%b exp=%b", obs, e); end
        // ADD moved to M
        @(negedge clk); clearInputs();
        branchD = 1; rsD = 5; rtD = 6; regwriteM = 1; writeregM = 5;
        #1;
        e = (expStalls == 1) ? mk(0, 0, 2'b00, 2'b00, 1, 0, 5'd0, 4'd0)
                             : mk(0, 0, 2'b00, 2'b00, 0, 0, ST_DEC, FL_DEC);
        if (stallD === 1'b1) stalls++;
        total++;
        if (obs !== e) begin bad++; $display("FAIL branch_m got=%b exp=%b", obs, e); end
        // ADD in W
        @(negedge clk); clearInputs();
        branchD = 1; rsD = 5; rtD = 6; regwriteW = 1; writeregW = 5;
        #1;
        if (stallD === 1'b1) stalls++;
        total++;
        if (obs !== 17'd0) begin bad++; $display("FAIL branch_w got=%b exp=%b", obs, 17'd0); end
        total++;
        if (stalls != expStalls) begin bad++; $display("FAIL branch_count got=%0d exp=%0d", stalls, expStalls); end
        // load result in M feeding the second branch operand always waits
        @(negedge clk); clearInputs();
        branchD = 1; rsD = 1; rtD = 6; regwriteM = 1; memtoregM = 1; writeregM = 6;
        #1;
        e = mk(0, 0, 2'b00, 2'b00, 0, (expStalls == 1), ST_DEC, FL_DEC);
        total++;
        if (obs !== e) begin bad++; $display("FAIL branch_load_m got=%b exp=%b", obs, e); end
    endtask

    task automatic test_div();
        logic [16:0] e;
        int starts = 0;
        int stalls = 0;
        for (int c = 0; c <= DIVC; c++) begin
            @(negedge clk); clearInputs();
            divE = 1;
            #1;
            e = (c < DIVC) ? mk(0, (c == 0), 2'b00, 2'b00, 0, 0, ST_DIV, FL_DIV) : 17'd0;
            if (div_start === 1'b1) starts++;
            if (stallE === 1'b1) stalls++;
            total++;
            if (obs !== e) begin bad++; $display("FAIL div_cycle[%0d] got=%b exp=%b", c, obs, e); end
        end
        total++;
        if (starts != 1) begin bad++; $display("FAIL div_starts got=%0d exp=1", starts); end
        total++;
        if (stalls != DIVC) begin bad++; $display("FAIL div_stalls got=%0d exp=%0d", stalls, DIVC); end
        @(negedge clk); clearInputs(); #1;
        total++;
        if (obs !== 17'd0) begin bad++; $display("FAIL div_after got=%b exp=%b", obs, 17'd0); end
    endtask

    task automatic test_div_exc();
        logic [16:0] e;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk); clearInputs();
            divE = (c != 7) && (c != 8);
            excM = (c == 5) || (c == 7);
            #1;
            if (excM) e = mk(0, 0, 2'b00, 2'b00, 0, 0, 5'd0, FL_EXC);
            else if (divE) e = mk(0, (c == 0) || (c == 6), 2'b00, 2'b00, 0, 0, ST_DIV, FL_DIV);
            else e = 17'd0;
            total++;
            if (obs !== e) begin bad++; $display("FAIL div_exc[%0d] got=%b exp=%b", c, obs, e); end
        end
    endtask

    task automatic test_mem_txn(input int aLat, input int dLat, input logic isWrite);
        logic [16:0] e;
        int reqs = 0;
        int stalls = 0;
        for (int c = 0; c <= aLat + dLat; c++) begin
            @(negedge clk); clearInputs();
            memwriteM = isWrite; memreadM = !isWrite; memtoregM = !isWrite;
            data_addr_ok = (c == aLat);
            data_data_ok = (c == aLat + dLat);
            #1;
            e = mk((c <= aLat), 0, 2'b00, 2'b00, 0, 0,
                   (c < aLat + dLat) ? ST_MEM : 5'd0, (c < aLat + dLat) ? FL_MEM : 4'd0);
            if (data_req === 1'b1) reqs++;
            if (stallM === 1'b1) stalls++;
            total++;
            if (obs !== e) begin
                bad++; $display("FAIL mem_a%0d_d%0d[%0d] got=%b exp=%b", aLat, dLat, c, obs, e);
            end
        end
        total++;
        if (reqs != aLat + 1) begin bad++; $display("FAIL mem_req_count got=%0d exp=%0d", reqs, aLat + 1); end
        total++;
        if (stalls != aLat + dLat) begin bad++; $display("FAIL mem_stall_count got=%0d exp=%0d", stalls, aLat + dLat); end
        @(negedge clk); clearInputs(); #1;
        total++;
        if (obs !== 17'd0) begin bad++; $display("FAIL mem_after got=%b exp=%b", obs, 17'd0); end
    endtask

    task automatic test_mem_random();
        for (int i = 0; i < 10; i++) begin
            test_mem_txn(int'($urandom_range(0, 4)), int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_exc_mem();
        logic [16:0] e;
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk); clearInputs();
            memwriteM = (c <= 4);
            data_addr_ok = (c == 1);
            excM = (c == 2);
            data_data_ok = (c == 4);
            #1;
            if (c <= 1) e = mk(1, 0, 2'b00, 2'b00, 0, 0, ST_MEM, FL_MEM);
            else if (c <= 3) e = mk(0, 0, 2'b00, 2'b00, 0, 0, ST_MEM, FL_MEM);
            else if (c == 4) e = mk(0, 0, 2'b00, 2'b00, 0, 0, 5'd0, FL_EXC);
            else e = 17'd0;
            total++;
            if (obs !== e) begin bad++; $display("FAIL exc_mem[%0d] got=%b exp=%b", c, obs, e); end
        end
    endtask

    task automatic test_reset_mid();
        logic [16:0] e;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); clearInputs();
            memwriteM = 1;
            #1;
            e = mk(1, 0, 2'b00, 2'b00, 0, 0, ST_MEM, FL_MEM);
            total++;
            if (obs !== e) begin bad++; $display("FAIL rst_mid_req[%0d] got=%b exp=%b", c, obs, e); end
        end
        #1 rst = 1'b1;
        #1;
        total++;
        if (obs !== 17'd0) begin bad++; $display("FAIL rst_mid_async got=%b exp=%b", obs, 17'd0); end
        @(negedge clk);
        rst = 1'b0;
        clearInputs();
        #1;
        total++;
        if (obs !== 17'd0) begin bad++; $display("FAIL rst_mid_clean got=%b exp=%b", obs, 17'd0); end
        @(negedge clk); clearInputs();
        memwriteM = 1; data_addr_ok = 1;
        #1; e = mk(1, 0, 2'b00, 2'b00, 0, 0, ST_MEM, FL_MEM);
        total++;
        if (obs !== e) begin bad++; $display("FAIL rst_mid_newreq got=%b exp=%b", obs, e); end
        @(negedge clk); clearInputs();
        memwriteM = 1; data_data_ok = 1;
        #1;
        total++;
        if (obs !== 17'd0) begin bad++; $display("FAIL rst_mid_newdone got=%b exp=%b", obs, 17'd0); end
        @(negedge clk); clearInputs();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_use();
        test_forward_random();
        test_branch();
        test_div();
        test_div_exc();
        test_mem_txn(3, 3, 1'b1);
        test_mem_txn(0, 1, 1'b0);
        test_mem_random();
        test_exc_mem();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
